// File: rtl/ledstrip_pkg.sv
// Shared types and constants for the LED strip frame sequencing path.
package ledstrip_pkg;

  localparam int PIX_W               = 24;
  localparam int LED_IDX_W           = 9;
  localparam int REFRESH_DIV_DEFAULT = 262144;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT_PIX = 3'd2,
    OFFER    = 3'd3,
    ACCEPT   = 3'd4,
    FINISH   = 3'd5
  } state_t;

endpackage

// File: rtl/ledstrip_frame_sequencer_refresh_trigger.sv
// Periodic refresh tick plus on-demand request folded into a single
// one-deep pending flag; triggers that find it already set are reported.
module refresh_trigger
  import ledstrip_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_req,
  input  logic consume,
  output logic pending,
  output logic frame_skip
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic             trigger;

  assign tick    = (tick_cnt == CNT_LAST);
  assign trigger = tick | frame_req;

  // A trigger landing in the same cycle the FSM consumes pending re-arms it
  // rather than being dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt   <= '0;
      pending    <= 1'b0;
      frame_skip <= 1'b0;
    end else begin
      tick_cnt   <= tick ? '0 : tick_cnt + 1'b1;
      pending    <= trigger | (pending & ~consume);
      frame_skip <= trigger & pending & ~consume;
    end
  end

endmodule

// File: rtl/ledstrip_frame_sequencer.sv
// Frame-level sequencer: fetches each LED's GRB word from a fixed-latency
// pixel source and hands it to the WS2812B driver, flagging the last pixel.
module ledstrip_frame_sequencer
  import ledstrip_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT,
  parameter int MAX_LEDS    = 280,
  parameter int PIX_LAT     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [LED_IDX_W-1:0] num_leds,
  input  logic                 frame_req,
  output logic                 pix_req,
  output logic [LED_IDX_W-1:0] pix_addr,
  input  logic [PIX_W-1:0]     pix_data,
  output logic [PIX_W-1:0]     drv_data,
  output logic                 drv_valid,
  input  logic                 drv_ready,
  output logic                 drv_latch,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_skip,
  output logic [7:0]           frame_count
);

  localparam logic [LED_IDX_W-1:0] MAX_N    = LED_IDX_W'(MAX_LEDS);
  localparam logic [2:0]           LAT_INIT = 3'(PIX_LAT);

  state_t               state;
  state_t               state_next;
  logic                 pending;
  logic                 consume;
  logic                 start;
  logic                 last_pix;
  logic [LED_IDX_W-1:0] n_leds;
  logic [2:0]           lat;

  refresh_trigger #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_trigger (
    .clk       (clk),
    .reset     (reset),
    .frame_req (frame_req),
    .consume   (consume),
    .pending   (pending),
    .frame_skip(frame_skip)
  );

  assign start    = consume & (num_leds != '0);
  assign last_pix = (pix_addr == n_leds - 1'b1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start)            state_next = FETCH;
      FETCH:                          state_next = WAIT_PIX;
      WAIT_PIX: if (lat == 3'd1)      state_next = OFFER;
      OFFER:    if (drv_ready)        state_next = ACCEPT;
      ACCEPT:   if (!drv_ready)       state_next = last_pix ? FINISH : FETCH;
      FINISH:   if (drv_ready)        state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // Pending is consumed whenever IDLE sees it with enable high, including the
  // zero-LED case, so an empty request does not linger.
  always_comb begin
    pix_req = 1'b0;
    busy    = 1'b1;
    consume = 1'b0;
    case (state)
      IDLE: begin
        busy    = 1'b0;
        consume = pending & enable;
      end
      FETCH:   pix_req = 1'b1;
      default: ;
    endcase
  end

  // pix_addr doubles as the LED index; it only moves on the way into FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_leds      <= '0;
      pix_addr    <= '0;
      lat         <= '0;
      drv_data    <= '0;
      drv_valid   <= 1'b0;
      drv_latch   <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          n_leds   <= (num_leds > MAX_N) ? MAX_N : num_leds;
          pix_addr <= '0;
        end
        FETCH: lat <= LAT_INIT;
        WAIT_PIX: begin
          lat <= lat - 1'b1;
          if (lat == 3'd1) drv_data <= pix_data;
        end
        OFFER: if (drv_ready) begin
          drv_valid <= 1'b1;
          drv_latch <= last_pix;
        end
        ACCEPT: if (!drv_ready) begin
          drv_valid <= 1'b0;
          drv_latch <= 1'b0;
          if (!last_pix) pix_addr <= pix_addr + 1'b1;
        end
        FINISH: if (drv_ready) begin
          frame_done  <= 1'b1;
          frame_count <= frame_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ledstrip_frame_sequencer.sv
// Scoreboard bench: stimulus pushes the expected pixel stream and frame
// completions; a negedge monitor pops them as the driver accepts pixels.
module tb_ledstrip_frame_sequencer;

  localparam int TB_DIV   = 16384;
  localparam int MAX_LEDS = 280;
  localparam int PIX_LAT  = 2;

  typedef struct packed {
    logic        latch;
    logic [23:0] data;
  } pix_t;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        enable    = 1'b0;
  logic        frame_req = 1'b0;
  logic [8:0]  num_leds  = '0;
  logic        pix_req;
  logic [8:0]  pix_addr;
  logic [23:0] pix_data;
  logic [23:0] drv_data;
  logic        drv_valid;
  logic        drv_ready = 1'b1;
  logic        drv_latch;
  logic        busy;
  logic        frame_done;
  logic        frame_skip;
  logic [7:0]  frame_count;

  ledstrip_frame_sequencer #(
    .REFRESH_DIV(TB_DIV),
    .MAX_LEDS   (MAX_LEDS),
    .PIX_LAT    (PIX_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .num_leds   (num_leds),
    .frame_req  (frame_req),
    .pix_req    (pix_req),
    .pix_addr   (pix_addr),
    .pix_data   (pix_data),
    .drv_data   (drv_data),
    .drv_valid  (drv_valid),
    .drv_ready  (drv_ready),
    .drv_latch  (drv_latch),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_skip (frame_skip),
    .frame_count(frame_count)
  );

  always #25 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge reset) cyc <= reset ? 0 : cyc + 1;

  // Pixel source: {15'b0, addr} two cycles after pix_req, junk otherwise.
  logic        s1_vld, s2_vld;
  logic [8:0]  s1_addr, s2_addr;
  logic [23:0] junk;
  always @(posedge clk) begin
    s1_vld  <= pix_req;
    s1_addr <= pix_addr;
    s2_vld  <= s1_vld;
    s2_addr <= s1_addr;
    junk    <= {1'b1, 23'($urandom)};
  end
  assign pix_data = s2_vld ? {15'b0, s2_addr} : junk;

  // Driver: ready drops the cycle after it takes a pixel, busy 30 cycles.
  int drv_cnt;
  always @(posedge clk) begin
    if (drv_valid && drv_ready) begin
      drv_ready <= 1'b0;
      drv_cnt   <= 30;
    end else if (!drv_ready) begin
      if (drv_cnt <= 1) drv_ready <= 1'b1;
      else              drv_cnt   <= drv_cnt - 1;
    end
  end

  pix_t       exp_pix[$];
  logic [7:0] exp_done[$];
  logic [7:0] model_count;
  int tests = 0, fails = 0;
  int n_pixreq = 0, n_busy = 0, n_skip = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (pix_req)    n_pixreq++;
    if (busy)       n_busy++;
    if (frame_skip) n_skip++;
    if (drv_valid && drv_ready) begin
      if (exp_pix.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_pixel: got data %0d, none expected", drv_data);
      end else begin
        pix_t e;
        e = exp_pix.pop_front();
        check("pixel_data", drv_data, e.data);
        check("pixel_latch", drv_latch, e.latch);
      end
    end
    if (frame_done) begin
      if (exp_done.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_frame_done: got count %0d, none expected", frame_count);
      end else begin
        check("frame_done_count", frame_count, exp_done.pop_front());
      end
    end
  end

  task automatic push_frame(input int n);
    int   nn;
    pix_t e;
    nn = (n > MAX_LEDS) ? MAX_LEDS : n;
    if (nn == 0) return;
    for (int i = 0; i < nn; i++) begin
      e.latch = (i == nn - 1);
      e.data  = 24'(i);
      exp_pix.push_back(e);
    end
    model_count = model_count + 8'd1;
    exp_done.push_back(model_count);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    frame_req = 1'b0;
    exp_pix.delete();
    exp_done.delete();
    model_count = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic pulse_req(output int c);
    @(posedge clk); #1;
    frame_req = 1'b1;
    c = cyc;
    @(posedge clk); #1;
    frame_req = 1'b0;
  endtask

  task automatic wait_pixreq(input int budget, output int at);
    int k;
    k = 0;
    at = -1;
    while (k < budget) begin
      @(negedge clk);
      k++;
      if (pix_req) begin
        at = cyc;
        break;
      end
    end
    check("pix_req_seen", (at >= 0), 1);
  endtask

  task automatic wait_idle(input int budget);
    int k, base;
    k = 0;
    while ((exp_pix.size() != 0 || exp_done.size() != 0 || busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("frame_completion_in_time", (k < budget), 1);
    base = n_pixreq;
    repeat (50) @(negedge clk);
    check("no_extra_frame", n_pixreq - base, 0);
    check("idle_busy", busy, 0);
    check("idle_frame_count", frame_count, model_count);
  endtask

  initial begin
    int c, at, sbase, exp_skip, bbase, pbase, n1, n2, k;
    model_count = '0;

    repeat (2) @(negedge clk);
    check("rst_drv_valid", drv_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pix_req", pix_req, 0);
    check("rst_drv_data", drv_data, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_frame_skip", frame_skip, 0);

    // Periodic tick only, then an on-demand request after it
    enable = 1'b1;
    num_leds = 9'd3;
    do_reset();
    push_frame(3);
    wait_pixreq(TB_DIV + 100, at);
    check("tick_start_cycle", at, TB_DIV + 1);
    check("tick_first_addr", pix_addr, 0);
    wait_idle(1000);
    check("tick_frame_count", frame_count, 1);
    pulse_req(c);
    push_frame(3);
    wait_pixreq(20, at);
    check("req_start_cycle", at, c + 2);
    check("req_first_addr", pix_addr, 0);
    repeat (3) @(negedge clk);
    check("capture_cycle_data", drv_data, 0);
    wait_idle(1000);

    // Two requests during a frame: one queued frame, one skip
    do_reset();
    sbase = n_skip;
    num_leds = 9'd2;
    pulse_req(c);
    push_frame(2);
    repeat (8) @(posedge clk);
    pulse_req(c);
    push_frame(2);
    repeat (8) @(posedge clk);
    pulse_req(c);
    wait_idle(1000);
    check("skip_count", n_skip - sbase, 1);
    check("two_frames", frame_count, 2);

    // Randomised requests and mid-frame num_leds changes
    for (int it = 0; it < 6; it++) begin
      do_reset();
      sbase = n_skip;
      exp_skip = 0;
      n1 = $urandom_range(1, 6);
      num_leds = 9'(n1);
      pulse_req(c);
      push_frame(n1);
      repeat (3) @(posedge clk);
      n2 = $urandom_range(1, 6);
      num_leds = 9'(n2);
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin
        repeat ($urandom_range(2, 6)) @(posedge clk);
        pulse_req(c);
      end
      if (k > 0) begin
        push_frame(n2);
        exp_skip = k - 1;
      end
      wait_idle(2000);
      check("rand_skip_count", n_skip - sbase, exp_skip);
    end

    // enable low mid-frame: frame completes, pending held until re-enabled
    do_reset();
    num_leds = 9'd2;
    pulse_req(c);
    push_frame(2);
    repeat (5) @(posedge clk);
    #1 enable = 1'b0;
    pulse_req(c);
    wait_idle(1000);
    bbase = n_busy;
    repeat (100) @(negedge clk);
    check("disabled_no_busy", n_busy - bbase, 0);
    enable = 1'b1;
    push_frame(2);
    wait_idle(1000);
    check("reenabled_count", frame_count, 2);

    // Zero LEDs, then clamp of an oversize frame
    do_reset();
    num_leds = 9'd0;
    pbase = n_pixreq;
    bbase = n_busy;
    pulse_req(c);
    repeat (50) @(negedge clk);
    check("zero_no_pix_req", n_pixreq - pbase, 0);
    check("zero_no_busy", n_busy - bbase, 0);
    check("zero_count", frame_count, 0);
    num_leds = 9'd400;
    pbase = n_pixreq;
    pulse_req(c);
    push_frame(400);
    wait_idle(12000);
    check("clamp_pix_reqs", n_pixreq - pbase, MAX_LEDS);

    // Reset while in ACCEPT on index 1 of the second frame
    do_reset();
    num_leds = 9'd3;
    pulse_req(c);
    push_frame(3);
    wait_idle(1000);
    pulse_req(c);
    push_frame(3);
    k = 0;
    while (!(drv_valid && !drv_ready && pix_addr == 9'd1) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("reached_accept_idx1", (k < 400), 1);
    reset = 1'b1;
    exp_pix.delete();
    exp_done.delete();
    model_count = '0;
    #1;
    check("midrst_drv_valid", drv_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_count", frame_count, 0);
    check("midrst_drv_latch", drv_latch, 0);
    @(posedge clk); #1 reset = 1'b0;
    pulse_req(c);
    push_frame(3);
    wait_pixreq(20, at);
    check("restart_addr", pix_addr, 0);
    wait_idle(1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(90000 * 50);
    $display("FAIL watchdog: simulation exceeded cycle limit");
    $fatal(1, "watchdog");
  end

endmodule
